// File: rtl/fb_write_arbiter_if.sv
// Bus bundle between the framebuffer write arbiter and its neighbours:
// ctrl write handshake, fill engine control, and the registered port-A RAM signals.
interface fb_write_arbiter_if #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int WAIT_CNT_WIDTH = 8
) ();
    logic                      ctrl_req;
    logic [ADDR_WIDTH-1:0]     ctrl_addr;
    logic [DATA_WIDTH-1:0]     ctrl_data;
    logic                      ctrl_ack;
    logic                      fill_start;
    logic [DATA_WIDTH-1:0]     fill_value;
    logic                      fill_busy;
    logic                      fill_done;
    logic [ADDR_WIDTH-1:0]     ram_address;
    logic [DATA_WIDTH-1:0]     ram_data_out;
    logic                      ram_write_enable;
    logic                      ram_clk_enable;
    logic [WAIT_CNT_WIDTH-1:0] ctrl_wait_cycles;

    modport master (
        output ctrl_req, ctrl_addr, ctrl_data, fill_start, fill_value,
        input  ctrl_ack, fill_busy, fill_done, ram_address, ram_data_out,
               ram_write_enable, ram_clk_enable, ctrl_wait_cycles
    );

    modport slave (
        input  ctrl_req, ctrl_addr, ctrl_data, fill_start, fill_value,
        output ctrl_ack, fill_busy, fill_done, ram_address, ram_data_out,
               ram_write_enable, ram_clk_enable, ctrl_wait_cycles
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Shares framebuffer port A between single-byte ctrl writes and a whole-frame
// fill engine, with round-robin tie-breaking and fully registered RAM signals.
module fb_write_arbiter #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int FB_DEPTH       = 4096,
    parameter int WAIT_CNT_WIDTH = 8
) (
    input logic               clk_in,
    input logic               reset,
    fb_write_arbiter_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_DEPTH - 1);

    logic                      r_ctrl_ack;
    logic                      r_fill_busy;
    logic                      r_fill_last_wr;
    logic                      r_fill_done;
    logic [ADDR_WIDTH-1:0]     r_fill_addr;
    logic [DATA_WIDTH-1:0]     r_fill_value;
    logic                      r_last_grant;
    logic [ADDR_WIDTH-1:0]     r_ram_address;
    logic [DATA_WIDTH-1:0]     r_ram_data;
    logic                      r_ram_we;
    logic [WAIT_CNT_WIDTH-1:0] r_wait_cnt;

    logic w_ctrl_elig;
    logic w_grant_ctrl;
    logic w_grant_fill;
    logic w_fill_last;

    // Round-robin grant; during an ack cycle ctrl is not eligible so it cannot be re-granted.
    always_comb begin
        w_ctrl_elig  = 1'b0;
        w_grant_ctrl = 1'b0;
        w_grant_fill = 1'b0;
        w_fill_last  = 1'b0;
        w_ctrl_elig  = bus.ctrl_req & ~r_ctrl_ack;
        if (w_ctrl_elig && r_fill_busy) begin
            w_grant_ctrl = r_last_grant;
            w_grant_fill = ~r_last_grant;
        end else begin
            w_grant_ctrl = w_ctrl_elig;
            w_grant_fill = r_fill_busy;
        end
        w_fill_last = (r_fill_addr == LAST_ADDR);
    end

    // Registered RAM port, handshake, fill sweep and stall counter.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_ctrl_ack     <= 1'b0;
            r_fill_busy    <= 1'b0;
            r_fill_last_wr <= 1'b0;
            r_fill_done    <= 1'b0;
            r_fill_addr    <= '0;
            r_fill_value   <= '0;
            r_last_grant   <= 1'b0;
            r_ram_address  <= '0;
            r_ram_data     <= '0;
            r_ram_we       <= 1'b0;
            r_wait_cnt     <= '0;
        end else begin
            r_ctrl_ack     <= w_grant_ctrl;
            r_fill_last_wr <= w_grant_fill & w_fill_last;
            r_fill_done    <= r_fill_last_wr;

            if (w_grant_ctrl) begin
                r_ram_address <= bus.ctrl_addr;
                r_ram_data    <= bus.ctrl_data;
                r_ram_we      <= 1'b1;
                r_last_grant  <= 1'b0;
            end else if (w_grant_fill) begin
                r_ram_address <= r_fill_addr;
                r_ram_data    <= r_fill_value;
                r_ram_we      <= 1'b1;
                r_last_grant  <= 1'b1;
            end else begin
                r_ram_we      <= 1'b0;
            end

            // A fill grant implies busy, so start and advance are mutually exclusive.
            if (!r_fill_busy && bus.fill_start) begin
                r_fill_value <= bus.fill_value;
                r_fill_addr  <= '0;
                r_fill_busy  <= 1'b1;
            end else if (w_grant_fill) begin
                if (w_fill_last) begin
                    r_fill_busy <= 1'b0;
                end else begin
                    r_fill_addr <= r_fill_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end else begin
                r_fill_busy <= r_fill_busy;
            end

            if (w_ctrl_elig && !w_grant_ctrl && !(&r_wait_cnt)) begin
                r_wait_cnt <= r_wait_cnt + {{(WAIT_CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end
        end
    end

    assign bus.ctrl_ack         = r_ctrl_ack;
    assign bus.fill_busy        = r_fill_busy;
    assign bus.fill_done        = r_fill_done;
    assign bus.ram_address      = r_ram_address;
    assign bus.ram_data_out     = r_ram_data;
    assign bus.ram_write_enable = r_ram_we;
    assign bus.ram_clk_enable   = r_ram_we;
    assign bus.ctrl_wait_cycles = r_wait_cnt;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed self-checking bench for fb_write_arbiter: reset, ctrl writes, full
// fill sweep, contention, ignored inputs and reset mid-sweep.
module tb_fb_write_arbiter;
    logic clk_in = 1'b0;
    logic reset  = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_wr   = 0;

    fb_write_arbiter_if bus ();

    fb_write_arbiter dut (.clk_in(clk_in), .reset(reset), .bus(bus));

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic we, input logic [11:0] addr,
                           input logic [7:0] data, input logic ack);
        chk({tag, ".we"}, {31'd0, bus.ram_write_enable}, {31'd0, we});
        chk({tag, ".ce"}, {31'd0, bus.ram_clk_enable}, {31'd0, we});
        chk({tag, ".ack"}, {31'd0, bus.ctrl_ack}, {31'd0, ack});
        if (we) begin
            chk({tag, ".addr"}, {20'd0, bus.ram_address}, {20'd0, addr});
            chk({tag, ".data"}, {24'd0, bus.ram_data_out}, {24'd0, data});
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".we"},   {31'd0, bus.ram_write_enable}, 32'd0);
        chk({tag, ".ce"},   {31'd0, bus.ram_clk_enable}, 32'd0);
        chk({tag, ".ack"},  {31'd0, bus.ctrl_ack}, 32'd0);
        chk({tag, ".busy"}, {31'd0, bus.fill_busy}, 32'd0);
        chk({tag, ".done"}, {31'd0, bus.fill_done}, 32'd0);
        chk({tag, ".addr"}, {20'd0, bus.ram_address}, 32'd0);
        chk({tag, ".data"}, {24'd0, bus.ram_data_out}, 32'd0);
        chk({tag, ".wait"}, {24'd0, bus.ctrl_wait_cycles}, 32'd0);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        // Reset held with random inputs.
        bus.ctrl_req   = 1'($urandom);
        bus.ctrl_addr  = 12'($urandom);
        bus.ctrl_data  = 8'($urandom);
        bus.fill_start = 1'($urandom);
        bus.fill_value = 8'($urandom);
        repeat (3) step();
        chk_zero("rst");
        bus.ctrl_req   = 1'b0;
        bus.ctrl_addr  = 12'h000;
        bus.ctrl_data  = 8'h00;
        bus.fill_start = 1'b0;
        bus.fill_value = 8'h00;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle.we", {31'd0, bus.ram_write_enable}, 32'd0);
        end

        // Single ctrl write, then req held -> write every second cycle.
        bus.ctrl_req  = 1'b1;
        bus.ctrl_addr = 12'h123;
        bus.ctrl_data = 8'hA5;
        step(); chk_bus("ctrl1", 1'b1, 12'h123, 8'hA5, 1'b1);
        step(); chk_bus("ctrl1gap", 1'b0, 12'h000, 8'h00, 1'b0);
        step(); chk_bus("ctrl2", 1'b1, 12'h123, 8'hA5, 1'b1);
        bus.ctrl_req = 1'b0;
        step(); chk_bus("ctrlend", 1'b0, 12'h000, 8'h00, 1'b0);
        chk("ctrl.wait", {24'd0, bus.ctrl_wait_cycles}, 32'd0);

        // Fill alone with 0x3C; mid-sweep fill_start 0x77 and fill_value change are ignored.
        bus.fill_value = 8'h3C;
        bus.fill_start = 1'b1;
        step();
        bus.fill_start = 1'b0;
        chk("fill.busy0", {31'd0, bus.fill_busy}, 32'd1);
        chk("fill.we0", {31'd0, bus.ram_write_enable}, 32'd0);
        for (int i = 0; i < 4096; i++) begin
            step();
            chk_bus("fill", 1'b1, 12'(i), 8'h3C, 1'b0);
            chk("fill.busy", {31'd0, bus.fill_busy}, (i == 4095) ? 32'd0 : 32'd1);
            chk("fill.done", {31'd0, bus.fill_done}, 32'd0);
            if (i == 100) begin
                bus.fill_value = 8'h77;
                bus.fill_start = 1'b1;
            end else begin
                bus.fill_start = 1'b0;
            end
        end
        step();
        chk("fill.donepulse", {31'd0, bus.fill_done}, 32'd1);
        chk("fill.weoff", {31'd0, bus.ram_write_enable}, 32'd0);
        step();
        chk("fill.doneclr", {31'd0, bus.fill_done}, 32'd0);

        // Contention: ctrl granted, fill starts in the ack cycle, then tie -> fill wins once.
        bus.fill_value = 8'h00;
        bus.ctrl_addr  = 12'h0AB;
        bus.ctrl_data  = 8'h5A;
        bus.ctrl_req   = 1'b1;
        n_wr = 0;
        step(); chk_bus("cont.c1", 1'b1, 12'h0AB, 8'h5A, 1'b1); n_wr++;
        bus.fill_start = 1'b1;
        step(); chk_bus("cont.gap", 1'b0, 12'h000, 8'h00, 1'b0);
        chk("cont.busy", {31'd0, bus.fill_busy}, 32'd1);
        bus.fill_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k % 2 == 0) chk_bus("cont.fill", 1'b1, 12'(k / 2), 8'h00, 1'b0);
            else            chk_bus("cont.ctrl", 1'b1, 12'h0AB, 8'h5A, 1'b1);
            if (bus.ram_write_enable) n_wr++;
            if (k == 7) bus.ctrl_req = 1'b0;
        end
        chk("cont.wait", {24'd0, bus.ctrl_wait_cycles}, 32'd1);
        for (int i = 4; i < 4096; i++) begin
            step();
            chk_bus("cont.tail", 1'b1, 12'(i), 8'h00, 1'b0);
            if (bus.ram_write_enable) n_wr++;
        end
        chk("cont.writes", 32'(n_wr), 32'd4101);
        step();
        chk("cont.done", {31'd0, bus.fill_done}, 32'd1);
        chk("cont.waitend", {24'd0, bus.ctrl_wait_cycles}, 32'd1);

        // Reset in the middle of a sweep at fill address 0x400.
        bus.fill_value = 8'hE7;
        bus.fill_start = 1'b1;
        step();
        bus.fill_start = 1'b0;
        repeat (12'h401) step();
        chk_bus("mid.pre", 1'b1, 12'h400, 8'hE7, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("mid.async");
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mid.we", {31'd0, bus.ram_write_enable}, 32'd0);
            chk("mid.done", {31'd0, bus.fill_done}, 32'd0);
        end

        // New fill restarts at 0; first tie after reset goes to fill.
        bus.fill_value = 8'h81;
        bus.fill_start = 1'b1;
        step();
        bus.fill_start = 1'b0;
        bus.ctrl_addr  = 12'h321;
        bus.ctrl_data  = 8'h99;
        bus.ctrl_req   = 1'b1;
        step(); chk_bus("re.fill0", 1'b1, 12'h000, 8'h81, 1'b0);
        chk("re.wait", {24'd0, bus.ctrl_wait_cycles}, 32'd1);
        step(); chk_bus("re.ctrl", 1'b1, 12'h321, 8'h99, 1'b1);
        bus.ctrl_req = 1'b0;
        step(); chk_bus("re.fill1", 1'b1, 12'h001, 8'h81, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
Owns framebuffer write port A. It shares that port between two requesters:
- the UART control path, which writes single bytes;
- an internal fill engine, which clears or fills the whole frame to one byte value when a debug command triggers it.
Both sides use a req/ack handshake, contention is resolved round-robin, and all RAM-side signals are registered. The block sits between the control module and multimem port A, clocked by clk_root.

Parameters:
ADDR_WIDTH, 12, framebuffer port-A address width
DATA_WIDTH, 8, framebuffer port-A data width
FB_DEPTH, 4096, bytes per frame (64x32 pixels x 2 bytes, RGB565); fill sweeps 0..FB_DEPTH-1
WAIT_CNT_WIDTH, 8, width of the saturating ctrl wait counter

Ports:
clk_in  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
ctrl_req  input  1  control path write request; held high until ctrl_ack
ctrl_addr  input  ADDR_WIDTH  write address; stable while ctrl_req is high
ctrl_data  input  DATA_WIDTH  write data; stable while ctrl_req is high
ctrl_ack  output  1  one-cycle pulse; the ctrl write is on the RAM bus this cycle
fill_start  input  1  one-cycle pulse; begins a fill sweep
fill_value  input  DATA_WIDTH  fill byte; sampled only on an accepted fill_start
fill_busy  output  1  high while a sweep is in progress
fill_done  output  1  one-cycle pulse after the last fill write
ram_address  output  ADDR_WIDTH  to port A address
ram_data_out  output  DATA_WIDTH  to port A data-in
ram_write_enable  output  1  to port A write enable
ram_clk_enable  output  1  to port A clock enable; always equal to ram_write_enable
ctrl_wait_cycles  output  WAIT_CNT_WIDTH  saturating count of ctrl stall cycles (debug)

Behaviour:
Reset:
- reset low forces every output and internal register to 0 immediately, whatever the clock is doing. This includes fill_addr, the latched fill value, last_grant and the wait counter.
- Release is synchronous to the next edge.

Fill engine:
- fill_start is accepted only when fill_busy=0; a fill_start while busy is ignored.
- On acceptance: fill_value is latched, fill_addr<=0, fill_busy<=1.
- Changes to fill_value during a sweep have no effect.
- The fill requester is asserted whenever fill_busy=1.

Arbitration (evaluated every edge):
- ctrl is eligible when ctrl_req=1 and ctrl_ack=0 in the current cycle. Consequence: no re-grant during an ack cycle, so ctrl gets at most 1 write per 2 cycles.
- Exactly one eligible requester: it is granted.
- Both eligible: grant the one not granted last (last_grant register, 0=ctrl, 1=fill). After reset last_grant=0, so fill wins the first tie.
- No grant: ram_write_enable<=0. ram_address and ram_data_out hold their last values.

Grant to ctrl at edge E (registered, visible in the cycle after E):
- ram_address<=ctrl_addr, ram_data_out<=ctrl_data, ram_write_enable<=1, ctrl_ack<=1.
- ctrl_ack is high for exactly that one cycle.

Grant to fill at edge E:
- ram_address<=fill_addr, ram_data_out<=latched value, ram_write_enable<=1, fill_addr<=fill_addr+1.
- When the granted fill_addr == FB_DEPTH-1:
  - fill_busy<=0 at the same edge, so no further fill requests.
  - fill_done<=1 at the following edge, for one cycle.
- fill_addr is not incremented past FB_DEPTH-1 and never wraps mid-sweep.
- Uncontended fill writes one byte per cycle: FB_DEPTH consecutive write cycles.

Simultaneous events:
- fill_start and ctrl_req in the same cycle: fill is not yet busy, so ctrl is granted and the fill begins competing from the next edge.
- fill_start in the fill_done cycle is accepted (fill_busy is already 0).

Wait counter:
- ctrl_wait_cycles increments on each edge where ctrl_req=1, ctrl_ack=0 and ctrl is not granted.
- Saturates at 2^WAIT_CNT_WIDTH-1; cleared only by reset.

Arithmetic:
- fill_addr is ADDR_WIDTH bits and compared against FB_DEPTH-1.
- FB_DEPTH must be <= 2^ADDR_WIDTH.

Reset mid-sweep: the sweep is aborted, no fill_done is generated, and the next fill restarts at address 0.

Latency:
- Request sampled at edge E; RAM write and ack are visible in cycle E+1.
- An uncontended ctrl request is acked in the cycle after it is first sampled.
- A contended ctrl request is acked in at most 2 cycles.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0. Release, stay idle 10 cycles -> ram_write_enable stays 0.
- Single ctrl write: ctrl_req=1, addr 0x123, data 0xA5 -> next cycle ram_write_enable=1, ram_clk_enable=1, ram_address=0x123, ram_data_out=0xA5, ctrl_ack=1 for exactly 1 cycle. Keep req held -> writes repeat every 2 cycles.
- Fill alone: fill_start with value 0x3C -> 4096 consecutive write cycles, addresses 0x000..0xFFF, data 0x3C throughout. fill_busy falls after the 0xFFF write. fill_done pulses once, the cycle after the 0xFFF write.
- Contention: fill (value 0x00) in progress, ctrl holds req for 5 writes -> writes alternate ctrl/fill and each ack arrives <=2 cycles after req. The sweep takes 4096+5 write cycles with no fill address skipped. ctrl_wait_cycles equals the number of stalled cycles.
- Ignored inputs: fill_start with 0x77 while busy, and fill_value changed mid-sweep -> no restart, data stays at the original latched value.
- Reset mid-sweep at fill_addr 0x400 -> outputs 0 immediately and no fill_done. A new fill_start after release writes from address 0x000.
